mac_out_packer: RTL and testbench

- Downstream neighbour of the MAC engine: consumes its 32b result stream (d stream) and requantizes each result by signed saturation to 8, 16 or 32 bits.
- Packs consecutive results little-endian into 32b words and streams them to the output streamer sink.
- Emits a partial word with a reduced strobe at the end of a job of ctrl_i.len results; exposes progress and saturation flags to the controller.

---
 rtl/mac_out_packer_pkg.sv | 36 +++
 rtl/hwpe_stream_intf_stream.sv | 17 +
 rtl/mac_pack_sat.sv | 47 ++++
 rtl/mac_out_packer.sv | 170 +++++++++++++++++
 tb/tb_mac_out_packer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_out_packer_pkg.sv
// Shared types and constants for the MAC output packer.
//   ctrl_packer_t  : enable, clear, width (0=32b, 1=16b, 2/3=8b), len
//   flags_packer_t : cnt, sat_cnt, done
package mac_out_packer_pkg;

   localparam int unsigned PACK_CNT_W  = 16;
   localparam int unsigned PACK_DATA_W = 32;
   localparam int unsigned PACK_STRB_W = PACK_DATA_W / 8;

   localparam logic [1:0] PACK_W32 = 2'd0;
   localparam logic [1:0] PACK_W16 = 2'd1;
   localparam logic [1:0] PACK_W8  = 2'd2;

   typedef struct packed {
      logic                  enable;
      logic                  clear;
      logic [1:0]            width;
      logic [PACK_CNT_W-1:0] len;
   } ctrl_packer_t;

   typedef struct packed {
      logic [PACK_CNT_W-1:0] cnt;
      logic [PACK_CNT_W-1:0] sat_cnt;
      logic                  done;
   } flags_packer_t;

   // Index of the last lane in a word for a given width code (3 behaves as 8b).
   function automatic logic [1:0] lane_last(input logic [1:0] width);
      case (width)
         PACK_W32: lane_last = 2'd0;
         PACK_W16: lane_last = 2'd1;
         default:  lane_last = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream interface with byte strobe.
//   source drives valid/data/strb and samples ready; sink is the mirror.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, data, strb, input ready);
   modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/mac_pack_sat.sv
// Combinational signed saturation of a 32b value to 32/16/8 bits.
//   din   : signed input
//   width : width code (0=32b, 1=16b, 2/3=8b)
//   dout  : clipped value, sign-extended to 32b
//   sat   : high when clipping occurred
module mac_pack_sat
   import mac_out_packer_pkg::*;
(
   input  logic [31:0] din,
   input  logic [1:0]  width,
   output logic [31:0] dout,
   output logic        sat
);

   logic signed [31:0] x;
   assign x = $signed(din);

   // Clip against the selected range; 32b passes straight through.
   always_comb begin
      dout = din;
      sat  = 1'b0;
      case (width)
         PACK_W32: begin
            dout = din;
         end
         PACK_W16: begin
            if (x > 32'sd32767) begin
               dout = 32'h0000_7FFF;
               sat  = 1'b1;
            end else if (x < -32'sd32768) begin
               dout = 32'hFFFF_8000;
               sat  = 1'b1;
            end
         end
         default: begin
            if (x > 32'sd127) begin
               dout = 32'h0000_007F;
               sat  = 1'b1;
            end else if (x < -32'sd128) begin
               dout = 32'hFFFF_FF80;
               sat  = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/mac_out_packer.sv
// Requantizes the MAC result stream and packs lanes little-endian into 32b words.
//   clk_i, rst_ni : clock, async active-low reset
//   test_mode_i   : unused
//   d_i           : 32b signed result stream (sink)
//   q_o           : packed 32b words with byte strobe (source)
//   ctrl_i        : enable, clear, width, len
//   flags_o       : element count, saturation count, done pulse
module mac_out_packer
   import mac_out_packer_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = PACK_CNT_W
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  test_mode_i,
   hwpe_stream_intf_stream.sink   d_i,
   hwpe_stream_intf_stream.source q_o,
   input  ctrl_packer_t          ctrl_i,
   output flags_packer_t         flags_o
);

   logic [31:0]          r_pack,      n_pack;
   logic [1:0]           r_lane,      n_lane;
   logic [CNT_WIDTH-1:0] r_cnt,       n_cnt;
   logic [CNT_WIDTH-1:0] r_sat,       n_sat;
   logic [31:0]          r_out,       n_out;
   logic [3:0]           r_strb,      n_strb;
   logic                 r_out_valid, n_out_valid;
   logic                 r_out_last,  n_out_last;

   logic [CNT_WIDTH-1:0] len;
   logic [1:0]           lane_max;
   logic                 last_elem, word_done, out_free;
   logic                 ready_c, accept, drain;
   logic [31:0]          sat_data, lane_mask, merged;
   logic [4:0]           lane_shift;
   logic [3:0]           word_strb;
   logic                 sat_hit;
   logic                 unused_sig;

   assign unused_sig = test_mode_i ^ (^d_i.strb);

   mac_pack_sat u_sat (
      .din   (d_i.data),
      .width (ctrl_i.width),
      .dout  (sat_data),
      .sat   (sat_hit)
   );

   assign len       = CNT_WIDTH'(ctrl_i.len);
   assign lane_max  = lane_last(ctrl_i.width);
   assign last_elem = (r_cnt == len - CNT_WIDTH'(1));
   assign word_done = (r_lane == lane_max) | last_elem;
   assign out_free  = ~r_out_valid | q_o.ready;

   // Clear is gated in so no element is accepted and then thrown away.
   assign ready_c = ctrl_i.enable & ~ctrl_i.clear & (len != '0) & (r_cnt < len)
                  & (~word_done | out_free);
   assign accept  = d_i.valid & ready_c;
   assign drain   = r_out_valid & q_o.ready;

   // Lane placement and strobe of the word if it closes on the current lane.
   always_comb begin
      lane_mask  = 32'hFFFF_FFFF;
      lane_shift = 5'd0;
      word_strb  = 4'hF;
      case (ctrl_i.width)
         PACK_W32: begin
            lane_mask  = 32'hFFFF_FFFF;
            lane_shift = 5'd0;
            word_strb  = 4'hF;
         end
         PACK_W16: begin
            lane_mask  = 32'h0000_FFFF;
            lane_shift = {r_lane[0], 4'b0000};
            word_strb  = r_lane[0] ? 4'hF : 4'h3;
         end
         default: begin
            lane_mask  = 32'h0000_00FF;
            lane_shift = {r_lane, 3'b000};
            case (r_lane)
               2'd0:    word_strb = 4'h1;
               2'd1:    word_strb = 4'h3;
               2'd2:    word_strb = 4'h7;
               default: word_strb = 4'hF;
            endcase
         end
      endcase
   end

   assign merged = r_pack | ((sat_data & lane_mask) << lane_shift);

   // Next-state: clear wins, otherwise drain then accept.
   always_comb begin
      n_pack      = r_pack;
      n_lane      = r_lane;
      n_cnt       = r_cnt;
      n_sat       = r_sat;
      n_out       = r_out;
      n_strb      = r_strb;
      n_out_valid = r_out_valid;
      n_out_last  = r_out_last;

      if (ctrl_i.clear) begin
         n_pack      = '0;
         n_lane      = '0;
         n_cnt       = '0;
         n_sat       = '0;
         n_out       = '0;
         n_strb      = '0;
         n_out_valid = 1'b0;
         n_out_last  = 1'b0;
      end else begin
         if (drain) begin
            n_out_valid = 1'b0;
            n_out_last  = 1'b0;
         end
         if (accept) begin
            n_cnt = r_cnt + CNT_WIDTH'(1);
            if (sat_hit && (r_sat != '1)) begin
               n_sat = r_sat + CNT_WIDTH'(1);
            end
            if (word_done) begin
               n_out       = merged;
               n_strb      = word_strb;
               n_out_valid = 1'b1;
               n_out_last  = last_elem;
               n_lane      = '0;
               n_pack      = '0;
            end else begin
               n_pack = merged;
               n_lane = r_lane + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pack      <= '0;
         r_lane      <= '0;
         r_cnt       <= '0;
         r_sat       <= '0;
         r_out       <= '0;
         r_strb      <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         r_pack      <= n_pack;
         r_lane      <= n_lane;
         r_cnt       <= n_cnt;
         r_sat       <= n_sat;
         r_out       <= n_out;
         r_strb      <= n_strb;
         r_out_valid <= n_out_valid;
         r_out_last  <= n_out_last;
      end
   end

   assign d_i.ready = ready_c;
   assign q_o.valid = r_out_valid;
   assign q_o.data  = r_out;
   assign q_o.strb  = r_strb;

   // done marks the handshake of the word carrying the final element.
   assign flags_o.cnt     = PACK_CNT_W'(r_cnt);
   assign flags_o.sat_cnt = PACK_CNT_W'(r_sat);
   assign flags_o.done    = drain & r_out_last;

endmodule

// File: tb/tb_mac_out_packer.sv
// Randomized and directed bench for mac_out_packer against a lane-packing model.
module tb_mac_out_packer;
   import mac_out_packer_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          test_mode;
   ctrl_packer_t  ctrl;
   flags_packer_t flags;

   hwpe_stream_intf_stream #(.DATA_WIDTH(32)) d_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(32)) q_if ();

   always #5 clk = ~clk;

   mac_out_packer u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .test_mode_i (test_mode),
      .d_i         (d_if),
      .q_o         (q_if),
      .ctrl_i      (ctrl),
      .flags_o     (flags)
   );

   int n_checks = 0;
   int n_errs   = 0;
   int cyc;

   logic [31:0] vals[$];
   logic [31:0] exp_data[$];
   logic [3:0]  exp_strb[$];
   int          exp_sat;
   logic [31:0] obs_data[$];
   int          acc_cyc[$];
   int          hs_cyc[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Model: clip each value arithmetically, place lane i%L at bit (i%L)*lw.
   function automatic void build_model(input int width, input int len);
      int          lw, nl, lane, nbytes;
      longint      sv, hi, lo;
      logic [31:0] word, mask;
      lw = (width == 0) ? 32 : (width == 1) ? 16 : 8;
      nl = 32 / lw;
      hi = (64'sd1 <<< (lw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      mask = (lw == 32) ? 32'hFFFF_FFFF : ((32'd1 << lw) - 32'd1);
      exp_data.delete();
      exp_strb.delete();
      exp_sat = 0;
      word = '0;
      for (int i = 0; i < len; i++) begin
         sv = longint'($signed(vals[i]));
         if (sv > hi) begin sv = hi; exp_sat++; end
         else if (sv < lo) begin sv = lo; exp_sat++; end
         lane = i % nl;
         word = word | ((32'(sv) & mask) << (lane * lw));
         if (lane == nl - 1 || i == len - 1) begin
            nbytes = (lane + 1) * lw / 8;
            exp_data.push_back(word);
            exp_strb.push_back(4'((1 << nbytes) - 1));
            word = '0;
         end
      end
   endfunction

   // Clear, then stream one job with random valid/ready percentages.
   task automatic run_job(input int width, input int len, input int vpct, input int rpct);
      int          idx, nw, budget;
      logic        stall;
      logic [31:0] held_d;
      logic [3:0]  held_s;
      build_model(width, len);
      obs_data.delete();
      acc_cyc.delete();
      hs_cyc.delete();
      budget = 4000;
      @(posedge clk); #1;
      ctrl.clear  = 1'b1;
      ctrl.enable = 1'b0;
      ctrl.width  = 2'(width);
      ctrl.len    = 16'(len);
      d_if.valid  = 1'b0;
      q_if.ready  = 1'b0;
      @(posedge clk); #1;
      ctrl.clear  = 1'b0;
      ctrl.enable = 1'b1;
      idx = 0; nw = 0; cyc = 0; stall = 1'b0; held_d = '0; held_s = '0;
      while ((idx < len || nw < exp_data.size()) && cyc < budget) begin
         d_if.valid = (idx < len) && ($urandom_range(99) < 32'(vpct));
         d_if.data  = (idx < len) ? vals[idx] : 32'h0;
         q_if.ready = ($urandom_range(99) < 32'(rpct));
         @(negedge clk);
         if (stall) begin
            check("hold_valid", 32'(q_if.valid), 32'd1);
            check("hold_data", q_if.data, held_d);
            check("hold_strb", 32'(q_if.strb), 32'(held_s));
         end
         if (d_if.valid && d_if.ready) begin
            acc_cyc.push_back(cyc);
            idx++;
         end
         if (q_if.valid && q_if.ready) begin
            obs_data.push_back(q_if.data);
            hs_cyc.push_back(cyc);
            if (nw < exp_data.size()) begin
               check("word_data", q_if.data, exp_data[nw]);
               check("word_strb", 32'(q_if.strb), 32'(exp_strb[nw]));
               check("done_hs", 32'(flags.done), 32'(nw == exp_data.size() - 1));
            end else begin
               check("extra_word", 32'd1, 32'd0);
            end
            nw++;
            stall = 1'b0;
         end else begin
            check("done_idle", 32'(flags.done), 32'd0);
            stall  = q_if.valid;
            held_d = q_if.data;
            held_s = q_if.strb;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= budget) check("timeout", 32'd0, 32'd1);
      // Offer more data after the job: nothing more may be taken or produced.
      d_if.valid = 1'b1;
      d_if.data  = 32'h5A5A_5A5A;
      q_if.ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("end_ready", 32'(d_if.ready), 32'd0);
      check("end_qvalid", 32'(q_if.valid), 32'd0);
      check("end_cnt", 32'(flags.cnt), 32'(len));
      check("end_sat", 32'(flags.sat_cnt), 32'(exp_sat));
      check("end_nwords", 32'(nw), 32'(exp_data.size()));
      @(posedge clk); #1;
      d_if.valid = 1'b0;
   endtask

   initial begin
      int w, l, kind;
      rst_n      = 1'b0;
      test_mode  = 1'b0;
      ctrl       = '0;
      d_if.valid = 1'b0;
      d_if.data  = '0;
      d_if.strb  = 4'hF;
      q_if.ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_qvalid", 32'(q_if.valid), 32'd0);
      check("rst_dready", 32'(d_if.ready), 32'd0);
      check("rst_qdata", q_if.data, 32'd0);
      check("rst_qstrb", 32'(q_if.strb), 32'd0);
      check("rst_flags", 32'(flags.cnt) | 32'(flags.sat_cnt) | 32'(flags.done), 32'd0);
      rst_n = 1'b1;

      // 8b lanes with saturation on both ends.
      vals = '{32'd1, 32'hFFFF_FFFE, 32'd300, 32'hFFFF_FED4};
      run_job(2, 4, 100, 100);
      check("tp1_nwords", 32'(obs_data.size()), 32'd1);
      if (obs_data.size() >= 1) check("tp1_word", obs_data[0], 32'h807F_FE01);
      check("tp1_sat", 32'(flags.sat_cnt), 32'd2);

      // 16b lanes with a trailing partial word.
      vals = '{32'h1234, 32'h7_FFFF, 32'd5};
      run_job(1, 3, 100, 100);
      check("tp2_nwords", 32'(obs_data.size()), 32'd2);
      if (obs_data.size() >= 2) begin
         check("tp2_word0", obs_data[0], 32'h7FFF_1234);
         check("tp2_word1", obs_data[1], 32'h0000_0005);
      end
      check("tp2_sat", 32'(flags.sat_cnt), 32'd1);

      // 32b lanes under backpressure.
      vals = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
      run_job(0, 5, 100, 40);
      check("tp3_nwords", 32'(obs_data.size()), 32'd5);
      for (int i = 0; i < obs_data.size(); i++) check("tp3_order", obs_data[i], 32'(10 + i));

      // Full throughput: one element per cycle, word one cycle after its last lane.
      vals = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      run_job(2, 8, 100, 100);
      check("tp4_naccept", 32'(acc_cyc.size()), 32'd8);
      check("tp4_nhs", 32'(hs_cyc.size()), 32'd2);
      if (acc_cyc.size() == 8 && hs_cyc.size() == 2) begin
         check("tp4_span", 32'(acc_cyc[7] - acc_cyc[0]), 32'd7);
         check("tp4_lat0", 32'(hs_cyc[0]), 32'(acc_cyc[3] + 1));
         check("tp4_lat1", 32'(hs_cyc[1]), 32'(acc_cyc[7] + 1));
      end

      // Clear with a pending word and a partial word in flight.
      @(posedge clk); #1;
      ctrl.clear = 1'b1; ctrl.enable = 1'b0; ctrl.width = 2'd2; ctrl.len = 16'd8;
      @(posedge clk); #1;
      ctrl.clear = 1'b0; ctrl.enable = 1'b1;
      q_if.ready = 1'b0;
      d_if.valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         d_if.data = 32'(k + 100);
         @(posedge clk); #1;
      end
      d_if.valid = 1'b0;
      @(negedge clk);
      check("clr_pending", 32'(q_if.valid), 32'd1);
      check("clr_cnt_pre", 32'(flags.cnt), 32'd6);
      @(posedge clk); #1;
      ctrl.clear = 1'b1;
      @(posedge clk); #1;
      ctrl.clear = 1'b0;
      @(negedge clk);
      check("clr_qvalid", 32'(q_if.valid), 32'd0);
      check("clr_cnt", 32'(flags.cnt), 32'd0);
      vals = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_job(2, 4, 100, 100);
      check("clr_nwords", 32'(obs_data.size()), 32'd1);
      if (obs_data.size() >= 1) check("clr_word", obs_data[0], 32'h0403_0201);

      // Async reset with a pending output word.
      @(posedge clk); #1;
      ctrl.clear = 1'b1; ctrl.enable = 1'b0; ctrl.width = 2'd0; ctrl.len = 16'd3;
      @(posedge clk); #1;
      ctrl.clear = 1'b0; ctrl.enable = 1'b1;
      q_if.ready = 1'b0;
      d_if.valid = 1'b1;
      d_if.data  = 32'd7;
      @(posedge clk); #1;
      d_if.valid = 1'b0;
      @(negedge clk);
      check("rst2_pending", 32'(q_if.valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst2_qvalid", 32'(q_if.valid), 32'd0);
      check("rst2_cnt", 32'(flags.cnt), 32'd0);
      check("rst2_qdata", q_if.data, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      vals = '{32'd9, 32'hFFFF_0000, 32'h8000_0000};
      run_job(0, 3, 100, 100);

      // len == 0 accepts nothing.
      vals.delete();
      run_job(2, 0, 100, 100);

      // Random jobs.
      for (int j = 0; j < 30; j++) begin
         w = $urandom_range(3);
         l = $urandom_range(13);
         vals.delete();
         for (int i = 0; i < l; i++) begin
            kind = $urandom_range(2);
            if (kind == 0)      vals.push_back(32'($urandom_range(400)) - 32'd200);
            else if (kind == 1) vals.push_back(32'($urandom_range(140000)) - 32'd70000);
            else                vals.push_back($urandom);
         end
         run_job(w, l, 30 + $urandom_range(70), 30 + $urandom_range(70));
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
